// File: rtl/parallel_converter_n_to_1_ctrl.sv
// parallel_converter_n_to_1_ctrl
// Sequencer for an N-to-1 parallelism converter: captures one wide word of
// N_LANES coded blocks per accepted strobe, then steps the lane select once
// per downstream-ready cycle. Back-to-back words are accepted on the cycle
// the final lane is taken, so the block stream can run without bubbles.
// Optional build macro: PCS_CONV_LANE_MASK_EN adds i_lane_mask so that only
// selected lanes of each word are emitted.
module parallel_converter_n_to_1_ctrl #(
  parameter  int LEN_CODED_BLOCK = 66,
  parameter  int N_LANES         = 20,
  localparam int NB_INDEX        = $clog2(N_LANES)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_valid,
  input  logic                i_ds_ready,
`ifdef PCS_CONV_LANE_MASK_EN
  input  logic [N_LANES-1:0]  i_lane_mask,
`endif
  output logic                o_ready,
  output logic                o_load,
  output logic [NB_INDEX-1:0] o_index,
  output logic                o_valid,
  output logic                o_last,
  output logic                o_overrun
);

  if (N_LANES < 2 || LEN_CODED_BLOCK < 1) begin : g_bad_cfg
    $error("parallel_converter_n_to_1_ctrl: N_LANES must be >= 2 and LEN_CODED_BLOCK >= 1");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [NB_INDEX-1:0] index_q, index_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;

  logic [NB_INDEX-1:0] first_idx;
  logic [NB_INDEX-1:0] next_idx;
  logic [NB_INDEX-1:0] last_idx;
  logic                word_has_lanes;
  logic                at_last;
  logic                advance;
  logic                ready;
  logic                load;

`ifdef PCS_CONV_LANE_MASK_EN
  logic [N_LANES-1:0] mask_q, mask_d;
  logic               next_found;
  logic               first_found;

  // Lane positions derived from the incoming mask (first lane) and the
  // captured mask (successor of the current lane, final lane).
  always_comb begin
    first_idx   = '0;
    first_found = 1'b0;
    next_idx    = index_q;
    next_found  = 1'b0;
    last_idx    = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (i_lane_mask[i] && !first_found) begin
        first_idx   = NB_INDEX'(i);
        first_found = 1'b1;
      end
      if (mask_q[i] && !next_found && (NB_INDEX'(i) > index_q)) begin
        next_idx   = NB_INDEX'(i);
        next_found = 1'b1;
      end
      if (mask_q[i]) begin
        last_idx = NB_INDEX'(i);
      end
    end
    word_has_lanes = |i_lane_mask;
  end
`else
  // Every lane is emitted in order, so lane positions are fixed.
  always_comb begin
    first_idx      = '0;
    next_idx       = index_q + NB_INDEX'(1);
    last_idx       = NB_INDEX'(N_LANES - 1);
    word_has_lanes = 1'b1;
  end
`endif

  // Handshake terms: a new word is taken when idle or as the final lane leaves.
  always_comb begin
    at_last = (index_q == last_idx);
    advance = i_enable & valid_q & i_ds_ready;
    ready   = i_enable & ((state_q == IDLE) |
                          ((state_q == RUN) & valid_q & at_last & i_ds_ready));
    load    = i_enable & i_valid & ready;
  end

  // Next-state: a load overrides the final-lane retirement so back-to-back
  // words restart at the first lane without an idle cycle.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
`ifdef PCS_CONV_LANE_MASK_EN
    mask_d    = mask_q;
    if (load) begin
      mask_d = i_lane_mask;
    end
`endif
    if (load) begin
      if (word_has_lanes) begin
        state_d = RUN;
        valid_d = 1'b1;
        index_d = first_idx;
      end else begin
        state_d = IDLE;
        valid_d = 1'b0;
        index_d = '0;
      end
    end else if (advance) begin
      if (at_last) begin
        state_d = IDLE;
        valid_d = 1'b0;
        index_d = '0;
      end else begin
        index_d = next_idx;
      end
    end
    if (i_enable & i_valid & ~ready) begin
      overrun_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= IDLE;
      index_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PCS_CONV_LANE_MASK_EN
      mask_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef PCS_CONV_LANE_MASK_EN
      mask_q    <= mask_d;
`endif
    end
  end

  assign o_ready   = ready;
  assign o_load    = load;
  assign o_index   = index_q;
  assign o_valid   = valid_q;
  assign o_last    = valid_q & at_last;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_parallel_converter_n_to_1_ctrl.sv
// Testbench for parallel_converter_n_to_1_ctrl: directed scenarios followed
// by random traffic. A queue of expected blocks (lane, last) is filled when a
// word is accepted and drained when downstream takes a block; a monitor on
// the falling edge compares the DUT outputs to the head of that queue.
module tb_parallel_converter_n_to_1_ctrl;

  localparam int N  = 20;
  localparam int NB = $clog2(N);

  logic          clk = 1'b0;
  logic          rst, en, v, rdy;
  logic [N-1:0]  lane_mask;
  logic          o_ready, o_load, o_valid, o_last, o_overrun;
  logic [NB-1:0] o_index;

  typedef struct {
    int unsigned lane;
    bit          last;
  } blk_t;

  blk_t exp_q[$];
  bit   m_ovr;
  int   passed = 0;
  int   total  = 0;

  parallel_converter_n_to_1_ctrl #(.LEN_CODED_BLOCK(66), .N_LANES(N)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_enable   (en),
    .i_valid    (v),
    .i_ds_ready (rdy),
`ifdef PCS_CONV_LANE_MASK_EN
    .i_lane_mask(lane_mask),
`endif
    .o_ready    (o_ready),
    .o_load     (o_load),
    .o_index    (o_index),
    .o_valid    (o_valid),
    .o_last     (o_last),
    .o_overrun  (o_overrun)
  );

  always #5 clk = ~clk;

  // Controller can take a word when nothing is pending, or when the only
  // pending block is being taken this very cycle.
  function automatic bit model_ready();
    return en && (exp_q.size() == 0 || (exp_q.size() == 1 && rdy));
  endfunction

  task automatic push_word();
    logic [N-1:0] m;
    blk_t b;
`ifdef PCS_CONV_LANE_MASK_EN
    m = lane_mask;
`else
    m = '1;
`endif
    for (int l = 0; l < N; l++) begin
      if (m[l]) begin
        b.lane = l;
        b.last = 1'b0;
        exp_q.push_back(b);
      end
    end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
  endtask

  // Reference model, advanced at each rising edge from the applied inputs.
  always @(posedge clk) begin
    bit r;
    if (rst) begin
      exp_q.delete();
      m_ovr = 1'b0;
    end else begin
      r = model_ready();
      if (en && rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      if (en && v) begin
        if (r) push_word();
        else   m_ovr = 1'b1;
      end
    end
  end

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, act, expv);
  endtask

  // Monitor: compare presented outputs against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready",   int'(o_ready),   int'(model_ready()));
      check("load",    int'(o_load),    int'(model_ready() && v));
      check("overrun", int'(o_overrun), int'(m_ovr));
      check("valid",   int'(o_valid),   int'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        check("index", int'(o_index), int'(exp_q[0].lane));
        check("last",  int'(o_last),  int'(exp_q[0].last));
      end else begin
        check("idle_index", int'(o_index), 0);
        check("idle_last",  int'(o_last),  0);
      end
    end
  end

  task automatic tick(input logic e, input logic vv, input logic r);
    en  = e;
    v   = vv;
    rdy = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; v = 1'b0; rdy = 1'b1; lane_mask = '1;
    repeat (3) tick(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    tick(1'b1, 1'b0, 1'b1);

    // Single word with downstream always ready.
    tick(1'b1, 1'b1, 1'b1);
    repeat (22) tick(1'b1, 1'b0, 1'b1);

    // Back-to-back words, second strobe while the final lane is taken.
    tick(1'b1, 1'b1, 1'b1);
    repeat (19) tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    repeat (22) tick(1'b1, 1'b0, 1'b1);

    // Downstream stall on lane 5 with a strobe inside the stall.
    tick(1'b1, 1'b1, 1'b1);
    repeat (5) tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    repeat (17) tick(1'b1, 1'b0, 1'b1);
    do_reset();

    // Enable dropped at lane 7; strobes while disabled are ignored.
    tick(1'b1, 1'b1, 1'b1);
    repeat (7) tick(1'b1, 1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b1, 1'b1);
    repeat (15) tick(1'b1, 1'b0, 1'b1);

    // Reset in the middle of a word, with a strobe during reset.
    tick(1'b1, 1'b1, 1'b1);
    repeat (4) tick(1'b1, 1'b0, 1'b1);
    do_reset();
    repeat (2) tick(1'b1, 1'b0, 1'b1);

`ifdef PCS_CONV_LANE_MASK_EN
    lane_mask = N'(5);
    tick(1'b1, 1'b1, 1'b1);
    lane_mask = '1;
    repeat (4) tick(1'b1, 1'b0, 1'b1);
    lane_mask = '0;
    tick(1'b1, 1'b1, 1'b1);
    lane_mask = '1;
    repeat (3) tick(1'b1, 1'b0, 1'b1);
`endif

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
`ifdef PCS_CONV_LANE_MASK_EN
      lane_mask = ($urandom_range(0, 15) == 0) ? '0 : N'($urandom);
`endif
      rst = ($urandom_range(0, 499) == 0);
      tick(logic'($urandom_range(0, 9) != 0),
           logic'($urandom_range(0, 7) == 0),
           logic'($urandom_range(0, 3) != 0));
    end
    rst = 1'b0;
    repeat (40) tick(1'b1, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
